// File: rtl/bar_rr_sched.sv
// bar_rr_sched: round-robin sharing of one `bar` unit among NUM_REQ requesters; an in-order tag FIFO
// routes each `bar` response back to its requester. Optional watchdog flush under BAR_RR_SCHED_TIMEOUT_EN.

module bar_rr_sched_lane #(
    parameter int LANE  = 0,
    parameter int TAG_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_gnt,
    input  logic             i_pop,
    input  logic [TAG_W-1:0] i_pop_tag,
    output logic             o_req_ready,
    output logic             o_rsp_valid
);
    logic r_rsp_valid;

    assign o_req_ready = i_gnt;
    assign o_rsp_valid = r_rsp_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rsp_valid <= 1'b0;
        else          r_rsp_valid <= i_pop && (i_pop_tag == TAG_W'(LANE));
    end
endmodule

module bar_rr_sched #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int MAX_OUTST   = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]     i_req_a,
    input  logic [NUM_REQ*DATA_W-1:0]     i_req_b,
    output logic                          o_bar_valid,
    input  logic                          i_bar_ready,
    output logic [DATA_W-1:0]             o_bar_a,
    output logic [DATA_W-1:0]             o_bar_b,
    input  logic                          i_bar_rsp_valid,
    input  logic [DATA_W-1:0]             i_bar_rsp_data,
    output logic [NUM_REQ-1:0]            o_rsp_valid,
    output logic [DATA_W-1:0]             o_rsp_data,
    output logic [$clog2(MAX_OUTST):0]    o_outst_cnt,
`ifdef BAR_RR_SCHED_TIMEOUT_EN
    output logic                          o_timeout_pulse,
`endif
    output logic                          o_err_orphan
);
    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = $clog2(MAX_OUTST);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] OCC_LIM = (CNT_W+1)'(MAX_OUTST);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_OUTST < 2 || (MAX_OUTST & (MAX_OUTST - 1)) != 0 ||
        TIMEOUT_CYC < 2) begin : g_bad_param
        $error("bar_rr_sched: illegal parameter combination");
    end

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } iss_t;

    logic [NUM_REQ-1:0][DATA_W-1:0]   w_req_a, w_req_b;
    logic                             r_run;
    iss_t                             r_iss;
    logic                             r_iss_full;
    logic [TAG_W-1:0]                 r_rr_ptr;
    logic [MAX_OUTST-1:0][TAG_W-1:0]  r_tag_mem;
    logic [PTR_W-1:0]                 r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]                 r_cnt;
    logic                             r_err;
    logic [DATA_W-1:0]                r_rsp_data;

    logic                             w_flush;
    logic                             w_arb_en, w_gnt_any, w_push, w_pop, w_orphan;
    logic [NUM_REQ-1:0]               w_gnt_oh;
    logic [TAG_W-1:0]                 w_gnt_idx, w_head_tag;
    logic [CNT_W:0]                   w_occ;

    assign w_req_a = i_req_a;
    assign w_req_b = i_req_b;

    // Occupancy counts the issue register too, so a granted op always has a FIFO slot by push time.
    assign w_occ    = {1'b0, r_cnt} + (CNT_W+1)'(r_iss_full);
    assign w_arb_en = r_run & ~w_flush & (~r_iss_full | i_bar_ready) & (w_occ < OCC_LIM);
    assign w_push   = r_iss_full & i_bar_ready & ~w_flush;
    assign w_pop    = i_bar_rsp_valid & (r_cnt != '0) & ~w_flush;
    assign w_orphan = i_bar_rsp_valid & (r_cnt == '0);
    assign w_head_tag = r_tag_mem[r_rd_ptr];

    always_comb begin
        int               v_idx;
        logic [TAG_W-1:0] v_sel;
        v_idx     = 0;
        v_sel     = '0;
        w_gnt_oh  = '0;
        w_gnt_idx = '0;
        w_gnt_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
            v_sel = TAG_W'(v_idx);
            if (w_arb_en && !w_gnt_any && i_req_valid[v_sel]) begin
                w_gnt_any       = 1'b1;
                w_gnt_oh[v_sel] = 1'b1;
                w_gnt_idx       = v_sel;
            end
        end
    end

    // Holds ready low from reset assertion through the first clock after release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_run <= 1'b0;
        else          r_run <= 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_iss_full <= 1'b0;
            r_iss      <= '0;
            r_rr_ptr   <= '0;
        end else begin
            if (w_flush) begin
                r_iss_full <= 1'b0;
            end else if (w_gnt_any) begin
                r_iss_full <= 1'b1;
                r_iss      <= '{tag: w_gnt_idx, a: w_req_a[w_gnt_idx], b: w_req_b[w_gnt_idx]};
            end else if (w_push) begin
                r_iss_full <= 1'b0;
            end
            if (w_gnt_any)
                r_rr_ptr <= (w_gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + TAG_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tag_mem <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cnt     <= '0;
        end else if (w_flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cnt     <= '0;
        end else begin
            if (w_push) begin
                r_tag_mem[r_wr_ptr] <= r_iss.tag;
                r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_data <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_pop)    r_rsp_data <= i_bar_rsp_data;
            if (w_orphan) r_err      <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        bar_rr_sched_lane #(.LANE(g), .TAG_W(TAG_W)) u_lane (
            .i_clk       (i_clk),
            .i_rst_n     (i_rst_n),
            .i_gnt       (w_gnt_oh[g]),
            .i_pop       (w_pop),
            .i_pop_tag   (w_head_tag),
            .o_req_ready (o_req_ready[g]),
            .o_rsp_valid (o_rsp_valid[g])
        );
    end

`ifdef BAR_RR_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            w_to_idle;

    // The flush cycle itself is the pulse; state clears on the following edge.
    assign w_to_idle       = ~i_bar_rsp_valid & (r_cnt != '0);
    assign w_flush         = w_to_idle & (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign o_timeout_pulse = w_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                 r_to_cnt <= '0;
        else if (!w_to_idle || w_flush) r_to_cnt <= '0;
        else                          r_to_cnt <= r_to_cnt + TO_W'(1);
    end
`else
    assign w_flush = 1'b0;
`endif

    assign o_bar_valid  = r_iss_full;
    assign o_bar_a      = r_iss.a;
    assign o_bar_b      = r_iss.b;
    assign o_rsp_data   = r_rsp_data;
    assign o_outst_cnt  = r_cnt;
    assign o_err_orphan = r_err;
endmodule

// File: tb/tb_bar_rr_sched.sv
// Directed bench for bar_rr_sched: stimulus pushes expected issues/responses into queues,
// a negedge monitor pops and compares whenever bar or a requester sees a transfer.
`timescale 1ns/1ps
module tb_bar_rr_sched;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MO = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid, req_ready, rsp_valid;
    logic [NR*DW-1:0]  req_a, req_b;
    logic              bar_valid, bar_ready, bar_rsp_valid, err_orphan;
    logic [DW-1:0]     bar_a, bar_b, bar_rsp_data, rsp_data;
    logic [$clog2(MO):0] outst_cnt;
`ifdef BAR_RR_SCHED_TIMEOUT_EN
    logic              timeout_pulse;
`endif

    int n_chk = 0;
    int n_pass = 0;
    logic [15:0] exp_iss[$];
    logic [11:0] exp_rsp[$];

    always #5 clk = ~clk;

    bar_rr_sched #(.NUM_REQ(NR), .DATA_W(DW), .MAX_OUTST(MO), .TIMEOUT_CYC(64)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_req_valid     (req_valid),
        .o_req_ready     (req_ready),
        .i_req_a         (req_a),
        .i_req_b         (req_b),
        .o_bar_valid     (bar_valid),
        .i_bar_ready     (bar_ready),
        .o_bar_a         (bar_a),
        .o_bar_b         (bar_b),
        .i_bar_rsp_valid (bar_rsp_valid),
        .i_bar_rsp_data  (bar_rsp_data),
        .o_rsp_valid     (rsp_valid),
        .o_rsp_data      (rsp_data),
        .o_outst_cnt     (outst_cnt),
`ifdef BAR_RR_SCHED_TIMEOUT_EN
        .o_timeout_pulse (timeout_pulse),
`endif
        .o_err_orphan    (err_orphan)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [7:0] ba, input logic [7:0] bb);
        for (int i = 0; i < NR; i++) begin
            req_a[i*DW +: DW] = ba + 8'(i);
            req_b[i*DW +: DW] = bb + 8'(i);
        end
    endtask

    task automatic rsp(input logic [7:0] d, input logic [3:0] oh);
        bar_rsp_valid = 1'b1;
        bar_rsp_data  = d;
        exp_rsp.push_back({oh, d});
    endtask

    always @(negedge clk) begin
        if (bar_valid && bar_ready) begin
            if (exp_iss.size() == 0) begin
                n_chk++;
                $display("FAIL iss_unexpected: got %0h expected none", {bar_a, bar_b});
            end else chk("iss_ops", 32'({bar_a, bar_b}), 32'(exp_iss.pop_front()));
        end
        if (rsp_valid != '0) begin
            if (exp_rsp.size() == 0) begin
                n_chk++;
                $display("FAIL rsp_unexpected: got %0h expected none", {rsp_valid, rsp_data});
            end else chk("rsp_route", 32'({rsp_valid, rsp_data}), 32'(exp_rsp.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        req_valid = '1; req_a = '0; req_b = '0;
        bar_ready = 1'b0; bar_rsp_valid = 1'b0; bar_rsp_data = '0;
        cyc();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_bar_valid", 32'(bar_valid), 32'h0);
        chk("rst_bar_a", 32'(bar_a), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_cnt", 32'(outst_cnt), 32'h0);
        chk("rst_err", 32'(err_orphan), 32'h0);
        req_valid = '0;
        cyc(); rst_n = 1'b1;
        cyc(); cyc();

        // round robin 0,1,2,3,0 back-to-back with responses streaming in order
        cyc(); set_ops(8'h10, 8'h20); req_valid = 4'hF; bar_ready = 1'b1;
        #3 chk("rr_gnt0", 32'(req_ready), 32'h1); exp_iss.push_back(16'h1020);
        cyc(); #3 chk("rr_gnt1", 32'(req_ready), 32'h2); exp_iss.push_back(16'h1121);
        cyc(); rsp(8'hC0, 4'b0001);
        #3 chk("rr_gnt2", 32'(req_ready), 32'h4); exp_iss.push_back(16'h1222);
        cyc(); rsp(8'hC1, 4'b0010);
        #3 chk("rr_gnt3", 32'(req_ready), 32'h8); exp_iss.push_back(16'h1323);
        cyc(); rsp(8'hC2, 4'b0100);
        #3 chk("rr_gnt0_wrap", 32'(req_ready), 32'h1); exp_iss.push_back(16'h1020);
        cyc(); req_valid = '0; rsp(8'hC3, 4'b1000);
        cyc(); rsp(8'hC4, 4'b0001);
        cyc(); bar_rsp_valid = 1'b0;
        cyc(); cyc(); #3 chk("rr_cnt_drained", 32'(outst_cnt), 32'h0);

        // single op from requester 2, response 3 cycles after issue
        cyc(); req_a = 32'h005A0000; req_b = 32'h003C0000; req_valid = 4'b0100;
        #3 chk("lat_gnt", 32'(req_ready), 32'h4); exp_iss.push_back(16'h5A3C);
        cyc(); req_valid = '0;
        #3 chk("lat_bar_valid", 32'(bar_valid), 32'h1); chk("lat_bar_a", 32'(bar_a), 32'h5A);
        cyc(); #3 chk("lat_cnt1", 32'(outst_cnt), 32'h1);
        cyc();
        cyc(); rsp(8'hA5, 4'b0100); #3 chk("lat_rsp_early", 32'(rsp_valid), 32'h0);
        cyc(); bar_rsp_valid = 1'b0;
        #3 chk("lat_rsp_oh", 32'(rsp_valid), 32'h4); chk("lat_rsp_data", 32'(rsp_data), 32'hA5);
        chk("lat_cnt0", 32'(outst_cnt), 32'h0);

        // bar backpressure: held issue, no grants, resume when bar_ready returns
        cyc(); set_ops(8'h30, 8'h40); req_valid = 4'b0011; bar_ready = 1'b0;
        #3 chk("bp_gnt0", 32'(req_ready), 32'h1); exp_iss.push_back(16'h3040);
        for (int c = 0; c < 5; c++) begin
            cyc();
            #3 chk("bp_ready", 32'(req_ready), 32'h0);
            chk("bp_bar_valid", 32'(bar_valid), 32'h1);
            chk("bp_stable", 32'({bar_a, bar_b}), 32'h3040);
        end
        cyc(); bar_ready = 1'b1;
        #3 chk("bp_resume", 32'(req_ready), 32'h2); exp_iss.push_back(16'h3141);
        cyc(); req_valid = '0; #3 chk("bp_cnt1", 32'(outst_cnt), 32'h1);
        cyc(); rsp(8'h77, 4'b0001); #3 chk("bp_cnt2", 32'(outst_cnt), 32'h2);
        cyc(); rsp(8'h88, 4'b0010);
        cyc(); bar_rsp_valid = 1'b0;
        cyc(); #3 chk("bp_cnt0", 32'(outst_cnt), 32'h0);

        // fill to MAX_OUTST, then a response and a new request in the same cycle
        cyc(); set_ops(8'h50, 8'h60); req_valid = 4'hF;
        #3 chk("full_gnt2", 32'(req_ready), 32'h4); exp_iss.push_back(16'h5262);
        cyc(); #3 chk("full_gnt3", 32'(req_ready), 32'h8); exp_iss.push_back(16'h5363);
        cyc(); #3 chk("full_gnt0", 32'(req_ready), 32'h1); exp_iss.push_back(16'h5060);
        cyc(); #3 chk("full_gnt1", 32'(req_ready), 32'h2); exp_iss.push_back(16'h5161);
        cyc(); #3 chk("full_stall_a", 32'(req_ready), 32'h0);
        cyc(); #3 chk("full_stall_b", 32'(req_ready), 32'h0); chk("full_cnt4", 32'(outst_cnt), 32'h4);
        cyc(); req_valid = 4'b0001; req_a[7:0] = 8'h99; req_b[7:0] = 8'h66; rsp(8'h11, 4'b0100);
        #3 chk("full_stall_c", 32'(req_ready), 32'h0);
        cyc(); bar_rsp_valid = 1'b0;
        #3 chk("full_regrant", 32'(req_ready), 32'h1); chk("full_cnt3", 32'(outst_cnt), 32'h3);
        exp_iss.push_back(16'h9966);
        cyc(); req_valid = '0;
        cyc(); #3 chk("full_cnt4_again", 32'(outst_cnt), 32'h4);
        cyc(); rsp(8'h21, 4'b1000);
        cyc(); rsp(8'h22, 4'b0001);
        cyc(); rsp(8'h23, 4'b0010);
        cyc(); rsp(8'h24, 4'b0001);
        cyc(); bar_rsp_valid = 1'b0;
        cyc(); #3 chk("full_cnt0", 32'(outst_cnt), 32'h0);

        // orphan response
        cyc(); bar_rsp_valid = 1'b1; bar_rsp_data = 8'h5E;
        #3 chk("orph_err_before", 32'(err_orphan), 32'h0);
        cyc(); bar_rsp_valid = 1'b0;
        #3 chk("orph_err_set", 32'(err_orphan), 32'h1); chk("orph_no_rsp", 32'(rsp_valid), 32'h0);
        cyc(); cyc(); #3 chk("orph_err_hold", 32'(err_orphan), 32'h1);

        // reset mid-burst with a response in flight
        cyc(); set_ops(8'h70, 8'h80); req_valid = 4'hF;
        #3 chk("mid_gnt1", 32'(req_ready), 32'h2); exp_iss.push_back(16'h7181);
        cyc(); #3 chk("mid_gnt2", 32'(req_ready), 32'h4); exp_iss.push_back(16'h7282);
        cyc(); bar_rsp_valid = 1'b1; bar_rsp_data = 8'hEE;
        #5 rst_n = 1'b0;
        #1 chk("mid_ready", 32'(req_ready), 32'h0);
        chk("mid_bar_valid", 32'(bar_valid), 32'h0);
        chk("mid_bar_ab", 32'({bar_a, bar_b}), 32'h0);
        chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rsp_data", 32'(rsp_data), 32'h0);
        chk("mid_cnt", 32'(outst_cnt), 32'h0);
        chk("mid_err", 32'(err_orphan), 32'h0);
        req_valid = '0; bar_rsp_valid = 1'b0; bar_ready = 1'b0;
        cyc(); cyc(); rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc();
            #3 chk("post_rst_rsp", 32'(rsp_valid), 32'h0);
            chk("post_rst_cnt", 32'(outst_cnt), 32'h0);
        end

        cyc(); cyc();
        chk("iss_q_empty", 32'(exp_iss.size()), 32'h0);
        chk("rsp_q_empty", 32'(exp_rsp.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bar_rr_sched.md
Name: bar_rr_sched

Overview:
- Round-robin scheduler that shares one `bar` unit among NUM_REQ requesters inside `foo`-style wrappers.
- Arbitrates requests and registers the winning operand pair toward `bar`.
- Tracks in-order outstanding operations with a tag FIFO and routes each `bar` response back to its originating requester.
- Instantiated once per shared `bar`; the optional third `bar` under the FOO generate label gets its own scheduler instance.

Parameters:
- NUM_REQ, 4: number of requesters; range 2..8.
- DATA_W, 8: operand and response width.
- MAX_OUTST, 4: tag FIFO depth, i.e. maximum operations in flight in `bar`. Power of two, at least 2.
- TIMEOUT_CYC, 64: watchdog limit in cycles. Used only with BAR_RR_SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all state is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_a  in  NUM_REQ*DATA_W  packed operand a; requester i uses slice [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  packed operand b, same packing.
- bar_valid  out  1  issue valid toward `bar`.
- bar_ready  in  1  `bar` accepts the issue.
- bar_a  out  DATA_W  registered operand a.
- bar_b  out  DATA_W  registered operand b.
- bar_rsp_valid  in  1  `bar` result valid; one pulse per accepted issue, returned in order.
- bar_rsp_data  in  DATA_W  `bar` result.
- rsp_valid  out  NUM_REQ  one-hot response strobe to the originating requester.
- rsp_data  out  DATA_W  response data, shared by all requesters.
- outst_cnt  out  $clog2(MAX_OUTST)+1  number of operations in flight.
- err_orphan  out  1  sticky: a response arrived while outstanding count was 0.

Behaviour:
- Reset (async assert, sync release): all outputs 0; rr pointer=0; issue register empty; tag FIFO empty.
- Issue register states:
  - EMPTY: bar_valid=0.
  - FULL: bar_valid=1. bar_a, bar_b and the stored tag must stay stable until bar_ready.
- Arbitration is enabled when issue register is EMPTY, or FULL and bar_ready=1 this cycle; and (outst_cnt + issue-register occupancy) < MAX_OUTST.
- Grant when enabled: first i with req_valid[i]=1, searching from rr pointer upward modulo NUM_REQ.
  - req_ready[grant]=1, combinational from req_valid and state; no other requester sees ready.
- On handshake req_valid[i] & req_ready[i]:
  - Next cycle: issue register loads req_a/req_b slice i plus tag i; bar_valid=1.
  - rr pointer becomes (i+1) mod NUM_REQ.
  - rr pointer is unchanged when nothing is granted.
- bar_valid & bar_ready pushes the tag into the tag FIFO; outst_cnt increments.
  - If a new grant happens the same cycle, the register reloads back-to-back: throughput 1 op/cycle.
- bar_rsp_valid pops the FIFO head tag t.
  - Next cycle: rsp_valid[t]=1 for exactly one cycle, rsp_data=bar_rsp_data; outst_cnt decrements.
  - Latency from bar_rsp_valid to rsp_valid: 1 cycle.
- Push and pop in the same cycle: both occur; outst_cnt unchanged; FIFO pointers wrap modulo MAX_OUTST.
- Response while outst_cnt==0 (orphan): response dropped; rsp_valid stays 0; err_orphan set, cleared only by reset.
- Stall when outst_cnt==MAX_OUTST, or when MAX_OUTST-1 with the issue register FULL:
  - All req_ready=0.
  - Issue register holds its contents; it pushes only if space remains.
- Reset asserted mid-operation: in-flight ops are discarded; no rsp_valid is produced for them after release.

Optional Feature:
- Macro: BAR_RR_SCHED_TIMEOUT_EN.
- Defined:
  - Counter clears on any bar_rsp_valid or when outst_cnt==0; otherwise increments each cycle.
  - On reaching TIMEOUT_CYC: tag FIFO and outst_cnt flush to 0, issue register empties, and output timeout_pulse (1 bit) is high for 1 cycle.
  - Later orphan responses set err_orphan.
- Undefined: no counter, no timeout_pulse port; the block waits indefinitely for responses.

Test Plan:
- NUM_REQ=4, all req_valid=4'b1111 held, bar_ready=1 -> grants go to 0,1,2,3,0 on consecutive cycles; bar_a follows each requester's slice 1 cycle after its grant.
- Requester 2 sends a=8'h5A; bar_rsp_valid 3 cycles after issue with data 8'hA5 -> rsp_valid=4'b0100 exactly 1 cycle later, rsp_data=8'hA5.
- bar_ready=0 for 5 cycles while req_valid=4'b0011 -> bar_valid stays 1, bar_a/bar_b stable, req_ready=0 throughout; grant resumes the cycle bar_ready=1.
- MAX_OUTST=4, no responses returned -> after 4 issues all req_ready=0 and outst_cnt=4. One response plus one new request in the same cycle -> outst_cnt stays 4 after the next issue.
- bar_rsp_valid pulsed with outst_cnt=0 -> no rsp_valid, err_orphan=1 and held. rst_n low mid-burst -> all outputs 0 asynchronously; no stale rsp_valid after release.
- With BAR_RR_SCHED_TIMEOUT_EN and TIMEOUT_CYC=16: 2 ops in flight, no responses -> timeout_pulse on the 16th idle cycle, then outst_cnt=0.
